// File: rtl/add8_err_pkg.sv
// Shared types and widths for the 8-bit adder error meter.
// Imported by the meter top and its stage-2 datapath.
package add8_err_pkg;

  localparam int OP_W  = 8;
  localparam int SUM_W = 9;
  localparam int SAE_W = 25;
  localparam int CNT_W = 17;
  localparam int HD_W  = 4;
  localparam int IDX_W = 2 * OP_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SUM_W-1:0] dut;
    logic [SUM_W-1:0] exact;
  } s1_t;

endpackage

// File: rtl/add8_err_stage.sv
// Stage-2 datapath: absolute error and Hamming distance
// between the adder result and the exact sum.
module add8_err_stage
  import add8_err_pkg::*;
(
  input  logic [SUM_W-1:0] dut,
  input  logic [SUM_W-1:0] exact,
  output logic [SUM_W-1:0] abs_err,
  output logic [HD_W-1:0]  hd
);

  // unsigned |dut - exact| and popcount of differing bits
  always_comb begin
    abs_err = (dut >= exact) ? (dut - exact) : (exact - dut);
    hd = '0;
    for (int i = 0; i < SUM_W; i++) begin
      hd = hd + HD_W'(dut[i] ^ exact[i]);
    end
  end

endmodule

// File: rtl/add8_err_meter.sv
// Exhaustive operand sweep of an external 8-bit adder with
// a two-stage pipeline accumulating error statistics.
module add8_err_meter
  import add8_err_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [OP_W-1:0]  a_o,
  output logic [OP_W-1:0]  b_o,
  input  logic [SUM_W-1:0] dut_o,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] wce,
  output logic [SAE_W-1:0] sae,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HD_W-1:0]  hd_max
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             drain_cnt;
  s1_t              s1;
  logic             sweeping;
  logic             accept;
  logic [SUM_W-1:0] exact;
  logic [SUM_W-1:0] e;
  logic [HD_W-1:0]  hd;

  assign sweeping = (state == ST_SWEEP);
  assign accept   = (state == ST_IDLE) && start;

  assign a_o   = sweeping ? idx[IDX_W-1:OP_W] : '0;
  assign b_o   = sweeping ? idx[OP_W-1:0] : '0;
  assign exact = {1'b0, a_o} + {1'b0, b_o};

  add8_err_stage u_stage (
    .dut     (s1.dut),
    .exact   (s1.exact),
    .abs_err (e),
    .hd      (hd)
  );

  // sequencer: sweep all pairs, flush two stages, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          idx <= idx + 1'b1;
          if (idx == '1) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // stage 1 capture and stage 2 accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      wce     <= '0;
      sae     <= '0;
      err_cnt <= '0;
      hd_max  <= '0;
    end else begin
      s1.valid <= sweeping;
      s1.dut   <= dut_o;
      s1.exact <= exact;
      if (accept) begin
        wce     <= '0;
        sae     <= '0;
        err_cnt <= '0;
        hd_max  <= '0;
      end else if (s1.valid) begin
        wce     <= (e > wce) ? e : wce;
        sae     <= sae + SAE_W'(e);
        err_cnt <= err_cnt + CNT_W'(e != '0);
        hd_max  <= (hd > hd_max) ? hd : hd_max;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_meter.sv
// Directed bench for add8_err_meter with a behavioural
// adder under test selectable between exact and faulty.
module tb_add8_err_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic [8:0]  dut_o;
  logic        busy;
  logic        done;
  logic [8:0]  wce;
  logic [24:0] sae;
  logic [16:0] err_cnt;
  logic [3:0]  hd_max;

  int          mode = 0;
  logic [8:0]  ex;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  longint      cyc = 0;
  longint      d1;
  longint      d2;
  longint      d3;

  add8_err_meter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_o     (a_o),
    .b_o     (b_o),
    .dut_o   (dut_o),
    .busy    (busy),
    .done    (done),
    .wce     (wce),
    .sae     (sae),
    .err_cnt (err_cnt),
    .hd_max  (hd_max)
  );

  always #5 clk = ~clk;

  // adder under test: 0 exact, 1 stuck at 0, 2 lsb flipped
  always_comb begin
    ex = {1'b0, a_o} + {1'b0, b_o};
    case (mode)
      1:       dut_o = '0;
      2:       dut_o = ex ^ 9'h001;
      default: dut_o = ex;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".a_o"}, 64'(a_o), 0);
    chk({tag, ".b_o"}, 64'(b_o), 0);
    chk({tag, ".busy"}, 64'(busy), 0);
    chk({tag, ".done"}, 64'(done), 0);
    chk({tag, ".wce"}, 64'(wce), 0);
    chk({tag, ".sae"}, 64'(sae), 0);
    chk({tag, ".err_cnt"}, 64'(err_cnt), 0);
    chk({tag, ".hd_max"}, 64'(hd_max), 0);
  endtask

  task automatic chk_stats(input string tag, input int w,
                           input int s, input int c,
                           input int h);
    chk({tag, ".wce"}, 64'(wce), 64'(w));
    chk({tag, ".sae"}, 64'(sae), 64'(s));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(c));
    chk({tag, ".hd_max"}, 64'(hd_max), 64'(h));
  endtask

  // call at a negedge in IDLE; returns at the done negedge
  task automatic run_sweep(input string tag, input bit poke,
                           output longint dcyc);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    chk({tag, ".busy0"}, 64'(busy), 1);
    chk({tag, ".wce0"}, 64'(wce), 0);
    chk({tag, ".sae0"}, 64'(sae), 0);
    while (done !== 1'b1 && n < 70000) begin
      if (poke) start = (n == 100) || (n == 65537);
      if (n == 300) begin
        chk({tag, ".a300"}, 64'(a_o), 1);
        chk({tag, ".b300"}, 64'(b_o), 44);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(n), 65538);
    chk({tag, ".busy_done"}, 64'(busy), 0);
    dcyc = cyc;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.busy", 64'(busy), 0);
    chk("idle.done_cnt", 64'(done_cnt), 0);

    mode = 0;
    run_sweep("exact", 1'b1, d1);
    chk_stats("exact", 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("exact.done_pulse", 64'(done), 0);
    chk("exact.done_cnt", 64'(done_cnt), 1);
    chk("exact.idle_busy", 64'(busy), 0);

    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30000) @(negedge clk);
    chk("abort.a_mid", 64'(a_o), 64'(30000 >> 8));
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort.done_cnt", 64'(done_cnt), 1);
    chk("abort.busy", 64'(busy), 0);

    run_sweep("stuck0", 1'b0, d2);
    chk_stats("stuck0", 510, 16711680, 65535, 8);

    mode = 2;
    @(negedge clk);
    chk("stuck0.done_pulse", 64'(done), 0);
    chk("stuck0.hold_wce", 64'(wce), 510);
    run_sweep("xor1", 1'b0, d3);
    chk_stats("xor1", 1, 65536, 65536, 1);
    chk("xor1.gap", 64'(d3 - d2), 65540);
    repeat (3) @(negedge clk);
    chk("final.done_cnt", 64'(done_cnt), 3);
    chk("final.hold_sae", 64'(sae), 65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
